// File: rtl/four_two_encoder_pipe.sv
// Streaming 4-to-2 one-hot encoder with a small output FIFO and a saturating error counter.
// Optional build macro: FOUR_TWO_ENCODER_PRIORITY_EN (multi-hot words encode to the highest set bit).
module four_two_encoder_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [3:0]       d,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [1:0]       y,
    output logic             err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    logic [2:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [1:0]       enc_y;
    logic             enc_err;
    logic             push;
    logic             pop;
    logic [2:0]       head;

    always_comb begin
        enc_y   = '0;
        enc_err = 1'b0;
`ifdef FOUR_TWO_ENCODER_PRIORITY_EN
        casez (d)
            4'b1???: enc_y = 2'd3;
            4'b01??: enc_y = 2'd2;
            4'b001?: enc_y = 2'd1;
            4'b0001: enc_y = 2'd0;
            default: enc_err = 1'b1;
        endcase
`else
        case (d)
            4'b0001: enc_y = 2'd0;
            4'b0010: enc_y = 2'd1;
            4'b0100: enc_y = 2'd2;
            4'b1000: enc_y = 2'd3;
            default: enc_err = 1'b1;
        endcase
`endif
    end

    // Ready depends only on registered occupancy, so a full FIFO never passes through.
    assign d_ready = (count != COUNT_FULL);
    assign y_valid = (count != '0);
    assign push    = d_valid && d_ready;
    assign pop     = y_valid && y_ready;
    assign head    = mem[rd_ptr];
    assign y       = y_valid ? head[1:0] : '0;
    assign err     = y_valid ? head[2]   : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_err, enc_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (push && enc_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_four_two_encoder_pipe.sv
// Directed self-checking bench for four_two_encoder_pipe (DEPTH=2, CNT_W=2).
module tb_four_two_encoder_pipe;

    logic       clk;
    logic       rst_n;
    logic       d_valid;
    logic       d_ready;
    logic [3:0] d;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] y;
    logic       err;
    logic       clr_cnt;
    logic [1:0] err_cnt;

    int unsigned checks;
    int unsigned failures;
    int unsigned exp_cnt;

    four_two_encoder_pipe #(
        .DEPTH(2),
        .CNT_W(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .d      (d),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .y      (y),
        .err    (err),
        .clr_cnt(clr_cnt),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        d_valid  = 1'b0;
        d        = 4'b0000;
        y_ready  = 1'b0;
        clr_cnt  = 1'b0;

        // Reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y", y, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_d_ready", d_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_y_valid", y_valid, 0);
        check("idle_d_ready", d_ready, 1);

        // Streaming, one word per cycle
        y_ready = 1'b1;
        d_valid = 1'b1;
        d = 4'b0001;
        tick();
        check("st0_valid", y_valid, 1);
        check("st0_y", y, 0);
        check("st0_err", err, 0);
        d = 4'b0010;
        tick();
        check("st1_y", y, 1);
        check("st1_err", err, 0);
        d = 4'b0100;
        tick();
        check("st2_y", y, 2);
        check("st2_err", err, 0);
        d = 4'b1000;
        tick();
        check("st3_y", y, 3);
        check("st3_err", err, 0);
        check("st3_valid", y_valid, 1);
        d_valid = 1'b0;
        tick();
        check("st_drain_valid", y_valid, 0);
        check("st_drain_y", y, 0);

        // Backpressure and full
        y_ready = 1'b0;
        d_valid = 1'b1;
        d = 4'b0100;
        tick();
        check("bp1_d_ready", d_ready, 1);
        check("bp1_y", y, 2);
        d = 4'b1000;
        tick();
        check("bp2_d_ready", d_ready, 0);
        check("bp2_y", y, 2);
        d = 4'b0010;
        tick();
        check("bp_hold_d_ready", d_ready, 0);
        check("bp_hold_y", y, 2);
        check("bp_hold_err", err, 0);
        y_ready = 1'b1;
        tick();
        check("bp_pop1_d_ready", d_ready, 1);
        check("bp_pop1_y", y, 3);
        // count=1: push third word while popping second
        tick();
        check("pp_valid", y_valid, 1);
        check("pp_y", y, 1);
        check("pp_d_ready", d_ready, 1);
        d_valid = 1'b0;
        tick();
        check("pp_drain_valid", y_valid, 0);

        // Malformed words
        d_valid = 1'b1;
        d = 4'b0000;
        tick();
        check("mf0_y", y, 0);
        check("mf0_err", err, 1);
        check("mf0_cnt", err_cnt, 1);
        d = 4'b0011;
        tick();
`ifdef FOUR_TWO_ENCODER_PRIORITY_EN
        check("mf1_y", y, 1);
        check("mf1_err", err, 0);
        check("mf1_cnt", err_cnt, 1);
`else
        check("mf1_y", y, 0);
        check("mf1_err", err, 1);
        check("mf1_cnt", err_cnt, 2);
`endif
        d = 4'b1111;
        tick();
`ifdef FOUR_TWO_ENCODER_PRIORITY_EN
        check("mf2_y", y, 3);
        check("mf2_err", err, 0);
        check("mf2_cnt", err_cnt, 1);
        exp_cnt = 1;
`else
        check("mf2_y", y, 0);
        check("mf2_err", err, 1);
        check("mf2_cnt", err_cnt, 3);
        exp_cnt = 3;
`endif

        // Saturation at 3 for a 2-bit counter
        d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (exp_cnt < 3) exp_cnt++;
            check("sat_cnt", err_cnt, exp_cnt);
            check("sat_err", err, 1);
        end
        check("sat_final", err_cnt, 3);

        // Clear wins over simultaneous malformed push
        clr_cnt = 1'b1;
        tick();
        check("clr_cnt", err_cnt, 0);
        clr_cnt = 1'b0;
        d_valid = 1'b0;
        tick();
        check("clr_hold", err_cnt, 0);
        check("clr_drain_valid", y_valid, 0);

        // Reset mid-stream with a full FIFO
        y_ready = 1'b0;
        d_valid = 1'b1;
        d = 4'b0000;
        tick();
        d = 4'b0001;
        tick();
        d_valid = 1'b0;
        check("full_d_ready", d_ready, 0);
        check("full_cnt", err_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_y_valid", y_valid, 0);
        check("mrst_d_ready", d_ready, 1);
        check("mrst_err_cnt", err_cnt, 0);
        check("mrst_y", y, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", y_valid, 0);
        check("post_rst_d_ready", d_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
